// File: rtl/reg_file_data_memory_if.sv
// Bus bundle between the RV32I datapath and its register file / data memory.
// master = datapath (drives addresses and write data), slave = storage block.
interface reg_file_data_memory_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    modport master (
        output A1, A2, A3, WD3, WE3, A, WD, WE,
        input  RD1, RD2, RD
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, A, WD, WE,
        output RD1, RD2, RD
    );
endinterface

// File: rtl/reg_file_data_memory.sv
// 32x32 register file (x0 hardwired to zero) plus word-addressed data memory; optional RF_BYPASS_EN forwards WD3 to same-cycle reads.
// Latency: reads combinational, writes land on the rising edge of clk; synchronous active-high rst clears registers only.
// Backpressure: none, every access completes in a single cycle.
module reg_file_data_memory #(
    parameter int DMEM_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_data_memory_if.slave bus
);
    localparam int AW = $clog2(DMEM_DEPTH);

    logic [31:0] regs [32];
    // Word 10 (byte 0x28) carries a preloaded constant; reset never reloads memory.
    logic [31:0] mem [DMEM_DEPTH] = '{10: 32'h1234_5678, default: 32'h0};

    logic [AW-1:0] mem_idx;
    logic          rf_wr;
    logic [31:0]   rd1;
    logic [31:0]   rd2;
    logic          unused_addr_bits;

    assign mem_idx          = bus.A[AW+1:2];
    assign unused_addr_bits = ^{bus.A[31:AW+2], bus.A[1:0]};
    assign rf_wr            = bus.WE3 && !rst && (bus.A3 != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (rf_wr) begin
            regs[bus.A3] <= bus.WD3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.WE) begin
            mem[mem_idx] <= bus.WD;
        end
    end

    always_comb begin
        rd1 = (bus.A1 == 5'd0) ? 32'h0 : regs[bus.A1];
        rd2 = (bus.A2 == 5'd0) ? 32'h0 : regs[bus.A2];
`ifdef RF_BYPASS_EN
        // rf_wr already excludes x0, so forwarding never disturbs the zero register.
        if (rf_wr && (bus.A1 == bus.A3)) rd1 = bus.WD3;
        if (rf_wr && (bus.A2 == bus.A3)) rd2 = bus.WD3;
`endif
    end

    assign bus.RD1 = rd1;
    assign bus.RD2 = rd2;
    assign bus.RD  = mem[mem_idx];
endmodule

// File: tb/tb_reg_file_data_memory.sv
// Directed bench for reg_file_data_memory: a reference model updated each rising edge, compared every falling edge, plus literal checks.
module tb_reg_file_data_memory;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    reg_file_data_memory_if bus ();

    reg_file_data_memory #(.DMEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] regs_m [32];
    logic [31:0] mem_m  [DEPTH];
    bit          regs_known = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        mem_m[10] = 32'h1234_5678;
    end

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (bus.WE3 && !rst && bus.A3 == a) return bus.WD3;
`endif
        return regs_m[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
            regs_known = 1'b1;
        end else begin
            if (bus.WE3 && bus.A3 != 5'd0) regs_m[bus.A3] = bus.WD3;
            if (bus.WE) mem_m[widx(bus.A)] = bus.WD;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rd", bus.RD, mem_m[widx(bus.A)]);
        if (regs_known) begin
            chk("model_rd1", bus.RD1, exp_rd(bus.A1));
            chk("model_rd2", bus.RD2, exp_rd(bus.A2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        bus.A3 = a; bus.WD3 = d; bus.WE3 = 1'b1;
        tick();
        bus.WE3 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.A3 = 5'd0; bus.WD3 = 32'h0; bus.WE3 = 1'b0;
        bus.A = 32'h28; bus.WD = 32'h0; bus.WE = 1'b0;
        #1;
        chk("mem_init_word10", bus.RD, 32'h1234_5678);
        tick();
        rst = 1'b0;

        // Pre-load every register, then reset and confirm all read zero
        for (int i = 1; i < 32; i++) wr_reg(5'(i), 32'hA500_0000 | 32'(i));
        bus.A1 = 5'd7; #1;
        chk("preload_x7", bus.RD1, 32'hA500_0007);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.A1 = 5'(i); bus.A2 = 5'(31 - i); #1;
            chk("reset_rd1", bus.RD1, 32'h0);
            chk("reset_rd2", bus.RD2, 32'h0);
        end
        bus.A = 32'h28; #1;
        chk("reset_keeps_mem", bus.RD, 32'h1234_5678);

        // Register write/read and x0 discard
        wr_reg(5'd2, 32'd40);
        bus.A1 = 5'd2; #1;
        chk("x2_eq_40", bus.RD1, 32'h0000_0028);
        wr_reg(5'd0, 32'hFFFF_FFFF);
        bus.A2 = 5'd0; #1;
        chk("x0_zero", bus.RD2, 32'h0);

        // lw x1,0(x2)
        bus.A = bus.RD1; #1;
        chk("lw_rd", bus.RD, 32'h1234_5678);
        wr_reg(5'd1, bus.RD);
        bus.A1 = 5'd1; #1;
        chk("lw_writeback", bus.RD1, 32'h1234_5678);

        // Memory write, sub-word alias and wrap
        bus.A = 32'h100; bus.WD = 32'hDEAD_BEEF; bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0; #1;
        chk("mem_0x100", bus.RD, 32'hDEAD_BEEF);
        bus.A = 32'h102; #1;
        chk("mem_0x102", bus.RD, 32'hDEAD_BEEF);
        bus.A = 32'h100 + 4 * DEPTH; #1;
        chk("mem_wrap", bus.RD, 32'hDEAD_BEEF);

        // Reset beats same-cycle writes
        wr_reg(5'd5, 32'h33);
        rst = 1'b1; bus.A3 = 5'd5; bus.WD3 = 32'd7; bus.WE3 = 1'b1;
        bus.A = 32'h10; bus.WD = 32'd9; bus.WE = 1'b1;
        tick();
        rst = 1'b0; bus.WE3 = 1'b0; bus.WE = 1'b0;
        bus.A1 = 5'd5; #1;
        chk("rst_prio_x5", bus.RD1, 32'h0);
        chk("rst_prio_word4", bus.RD, 32'h0);

        // Same-cycle register write/read on x3
        wr_reg(5'd3, 32'h11);
        bus.A1 = 5'd3; bus.A3 = 5'd3; bus.WD3 = 32'h55; bus.WE3 = 1'b1; #1;
`ifdef RF_BYPASS_EN
        chk("x3_before_edge", bus.RD1, 32'h55);
`else
        chk("x3_before_edge", bus.RD1, 32'h11);
`endif
        tick();
        bus.WE3 = 1'b0; #1;
        chk("x3_after_edge", bus.RD1, 32'h55);

        // Same-cycle memory write/read
        bus.A = 32'h200; bus.WD = 32'h0000_CAFE; bus.WE = 1'b1; #1;
        chk("mem_old_before_edge", bus.RD, 32'h0);
        tick();
        bus.WE = 1'b0; #1;
        chk("mem_new_after_edge", bus.RD, 32'h0000_CAFE);

        // Mixed traffic, checked by the model on every falling edge
        for (int i = 0; i < 24; i++) begin
            bus.A3  = 5'((i * 7) % 32);
            bus.WD3 = 32'h1111_1111 * 32'(i);
            bus.WE3 = (i % 3) != 0;
            bus.A1  = 5'((i * 5) % 32);
            bus.A2  = bus.A3;
            bus.A   = 32'(i * 148 + (i % 4));
            bus.WD  = 32'hF000_0000 ^ 32'(i * 3);
            bus.WE  = (i % 2) != 0;
            tick();
        end
        bus.WE3 = 1'b0; bus.WE = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
